// File: rtl/tinyqv_prefetch_buffer.sv
// Instruction prefetch queue between the QSPI fetch port and the CPU decoder.
// Circular halfword store; the head instruction is presented as a 32-bit window.
module tinyqv_prefetch_buffer #(
   parameter int DEPTH_LOG2 = 2,
   parameter int ADDR_BITS  = 23
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic [ADDR_BITS-1:0]  fetch_addr_o,
   output logic                  fetch_restart_o,
   output logic                  fetch_stall_o,
   input  logic                  fetch_started_i,
   input  logic                  fetch_stopped_i,
   input  logic [15:0]           fetch_data_i,
   input  logic                  fetch_ready_i,
   output logic [ADDR_BITS-1:0]  pc_o,
   output logic [31:0]           instr_o,
   output logic [1:0]            instr_len_o,
   output logic                  instr_valid_o,
   input  logic                  instr_consume_i,
   input  logic                  redirect_i,
   input  logic [ADDR_BITS-1:0]  redirect_addr_i,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  overflow_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

   state_t                  state_q;
   logic                    stop_pend_q;
   logic [15:0]             mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   rd_ptr_q;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q;
   logic [DEPTH_LOG2-1:0]   rd_ptr_p1;
   logic [DEPTH_LOG2:0]     count_q;
   logic [DEPTH_LOG2:0]     count_d;
   logic [DEPTH_LOG2:0]     len_ext;
   logic [ADDR_BITS-1:0]    pc_q;
   logic [ADDR_BITS-1:0]    pc_d;
   logic                    overflow_q;
   logic                    full;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic                    ovf_set;

   assign rd_ptr_p1     = rd_ptr_q + DEPTH_LOG2'(1);
   assign instr_o       = {mem_q[rd_ptr_p1], mem_q[rd_ptr_q]};
   assign instr_len_o   = (instr_o[1:0] == 2'b11) ? 2'd2 : 2'd1;
   assign len_ext       = (DEPTH_LOG2+1)'(instr_len_o);
   assign instr_valid_o = (count_q >= len_ext);

   assign full    = (count_q == FULL);
   assign pop     = instr_consume_i && instr_valid_o && !redirect_i;
   assign accept  = fetch_ready_i && (state_q == ST_RUN) && !redirect_i;
   // A pop in the same cycle frees space, so a full buffer can still take a halfword.
   assign push    = accept && (!full || pop);
   assign ovf_set = accept && full && !pop;

   assign count_d = count_q + (DEPTH_LOG2+1)'(push) - (pop ? len_ext : '0);
   assign pc_d    = pc_q + (pop ? ADDR_BITS'(instr_len_o) : '0);

   assign fetch_addr_o    = pc_q + ADDR_BITS'(count_q);
   assign fetch_stall_o   = (state_q == ST_RUN) && (count_d == FULL);
   assign fetch_restart_o = (state_q == ST_IDLE) && !redirect_i && !rst_i;
   assign pc_o            = pc_q;
   assign count_o         = count_q;
   assign overflow_o      = overflow_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= fetch_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         stop_pend_q <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         pc_q        <= '0;
         overflow_q  <= 1'b0;
      end else begin
         overflow_q <= overflow_q | ovf_set;
         if (redirect_i) begin
            count_q  <= '0;
            rd_ptr_q <= wr_ptr_q;
            pc_q     <= redirect_addr_i;
         end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(instr_len_o);
            end
            if (push) begin
               wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
         end

         case (state_q)
            ST_IDLE: begin
               // A stop arriving with the start is replayed one cycle later from RUN.
               if (!redirect_i && fetch_started_i) begin
                  state_q     <= ST_RUN;
                  stop_pend_q <= fetch_stopped_i;
               end
            end
            ST_RUN: begin
               if (fetch_stopped_i || stop_pend_q) begin
                  state_q     <= ST_IDLE;
                  stop_pend_q <= 1'b0;
               end else if (redirect_i) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (fetch_stopped_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
